dcache_2way: RTL and testbench

Parametrised 2-way set-associative, write-back, write-allocate data cache for the RV32IM pipeline's MEM stage. It sits between the MEM stage and the block-wide data memory. It serves byte, half and word accesses in one cycle on a hit, and stalls the pipeline through `busywait` on a miss. It replaces the direct-mapped byte cache with configurable set count, configurable block size and LRU replacement.

---
 rtl/dcache_2way_if.sv | 31 +++
 rtl/dcache_2way.sv | 279 +++++++++++++++++++++++++++
 tb/tb_dcache_2way.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_2way_if.sv
// CPU-side and memory-side bus of the 2-way data cache.
// slave: the cache; master: the MEM stage plus the block-wide data memory.
interface dcache_2way_if #(
    parameter int unsigned WORD_BITS = 2,
    parameter int unsigned MEM_AW    = 30 - WORD_BITS
);
    logic                          read;
    logic                          write;
    logic [1:0]                    size;
    logic [31:0]                   address;
    logic [31:0]                   writedata;
    logic [31:0]                   readdata;
    logic                          busywait;
    logic                          misaligned;
    logic                          mem_read;
    logic                          mem_write;
    logic [MEM_AW-1:0]             mem_address;
    logic [(32<<WORD_BITS)-1:0]    mem_writedata;
    logic [(32<<WORD_BITS)-1:0]    mem_readdata;
    logic                          mem_busywait;

    modport slave (
        input  read, write, size, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, misaligned, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, size, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, misaligned, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU.
// Optional DCACHE_STATS_EN adds saturating hit/miss/writeback counters.
module dcache_2way #(
    parameter int unsigned SET_BITS  = 3,
    parameter int unsigned WORD_BITS = 2,
    parameter int unsigned MEM_AW    = 30 - WORD_BITS
) (
    input  logic           clock,
    input  logic           reset,
    dcache_2way_if.slave   bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count,
    output logic [31:0]    wb_count
`endif
);

    localparam int unsigned NSETS = 1 << SET_BITS;
    localparam int unsigned BLK_W = 32 << WORD_BITS;
    localparam int unsigned TAG_W = 32 - SET_BITS - WORD_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_UPDATE
    } state_e;

    state_e                state_q, state_d;

    logic                  valid_q [2][NSETS];
    logic                  valid_d [2][NSETS];
    logic                  dirty_q [2][NSETS];
    logic                  dirty_d [2][NSETS];
    logic                  lru_q   [NSETS];
    logic                  lru_d   [NSETS];
    logic [TAG_W-1:0]      tag_q   [2][NSETS];
    logic [TAG_W-1:0]      tag_d   [2][NSETS];
    logic [BLK_W-1:0]      data_q  [2][NSETS];
    logic [BLK_W-1:0]      data_d  [2][NSETS];

    logic                  victim_q, victim_d;
    logic [BLK_W-1:0]      refill_q, refill_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [MEM_AW-1:0]     mem_address_q, mem_address_d;
    logic [BLK_W-1:0]      mem_writedata_q, mem_writedata_d;

    logic [TAG_W-1:0]      req_tag;
    logic [SET_BITS-1:0]   req_idx;
    logic [WORD_BITS-1:0]  req_woff;
    logic [1:0]            req_boff;
    logic                  misaligned;
    logic                  access_en;
    logic                  hit0, hit1, hit, hit_way;
    logic                  victim_sel, victim_dirty;
    logic                  idle_hit;
    logic [BLK_W-1:0]      hit_blk, merged_blk;
    logic [31:0]           rd_word, rd_sh, rd_fmt, wr_sh, merged_word;
    logic [3:0]            wr_be;

    assign req_tag  = bus.address[31:SET_BITS+WORD_BITS+2];
    assign req_idx  = bus.address[SET_BITS+WORD_BITS+1:WORD_BITS+2];
    assign req_woff = bus.address[WORD_BITS+1:2];
    assign req_boff = bus.address[1:0];

    assign misaligned = ((bus.size == 2'b01) && bus.address[0]) ||
                        (bus.size[1] && (bus.address[1:0] != 2'b00));
    assign access_en  = reset && (bus.read || bus.write) && !misaligned;

    assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    assign idle_hit = (state_q == S_IDLE) && access_en && hit;

    // Way 0 is preferred when empty; LRU only decides once both ways are valid.
    assign victim_sel   = !valid_q[0][req_idx] ? 1'b0 :
                          !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign victim_dirty = valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx];

    assign hit_blk = data_q[hit_way][req_idx];
    assign rd_word = hit_blk[{req_woff, 5'b00000} +: 32];

    always_comb begin
        rd_sh = rd_word >> {req_boff, 3'b000};
        case (bus.size)
            2'b00:   rd_fmt = {24'h000000, rd_sh[7:0]};
            2'b01:   rd_fmt = {16'h0000, rd_sh[15:0]};
            default: rd_fmt = rd_sh;
        endcase
    end

    always_comb begin
        case (bus.size)
            2'b00:   wr_be = 4'b0001 << req_boff;
            2'b01:   wr_be = 4'b0011 << req_boff;
            default: wr_be = 4'b1111;
        endcase
        wr_sh       = bus.writedata << {req_boff, 3'b000};
        merged_word = rd_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                merged_word[b*8 +: 8] = wr_sh[b*8 +: 8];
            end
        end
        merged_blk = hit_blk;
        merged_blk[{req_woff, 5'b00000} +: 32] = merged_word;
    end

    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        refill_d        = refill_q;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_address_d   = '0;
        mem_writedata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (access_en && !hit) begin
                    victim_d = victim_sel;
                    if (victim_dirty) begin
                        state_d         = S_WRITEBACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {tag_q[victim_sel][req_idx], req_idx};
                        mem_writedata_d = data_q[victim_sel][req_idx];
                    end else begin
                        state_d       = S_REFILL;
                        mem_read_d    = 1'b1;
                        mem_address_d = bus.address[31:WORD_BITS+2];
                    end
                end
            end
            S_WRITEBACK: begin
                if (!bus.mem_busywait) begin
                    state_d       = S_REFILL;
                    mem_read_d    = 1'b1;
                    mem_address_d = bus.address[31:WORD_BITS+2];
                end else begin
                    mem_write_d     = 1'b1;
                    mem_address_d   = mem_address_q;
                    mem_writedata_d = mem_writedata_q;
                end
            end
            S_REFILL: begin
                if (!bus.mem_busywait) begin
                    state_d  = S_UPDATE;
                    refill_d = bus.mem_readdata;
                end else begin
                    mem_read_d    = 1'b1;
                    mem_address_d = mem_address_q;
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_d   = lru_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (idle_hit) begin
            lru_d[req_idx] = ~hit_way;
            if (bus.write) begin
                data_d[hit_way][req_idx]  = merged_blk;
                dirty_d[hit_way][req_idx] = 1'b1;
            end
        end
        if (state_q == S_UPDATE) begin
            data_d[victim_q][req_idx]  = refill_q;
            tag_d[victim_q][req_idx]   = req_tag;
            valid_d[victim_q][req_idx] = 1'b1;
            dirty_d[victim_q][req_idx] = 1'b0;
            lru_d[req_idx]             = ~victim_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            victim_q        <= 1'b0;
            refill_q        <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            for (int unsigned s = 0; s < NSETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int unsigned w = 0; w < 2; w++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            state_q         <= state_d;
            victim_q        <= victim_d;
            refill_q        <= refill_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            lru_q           <= lru_d;
        end
    end

    // Tags and data are qualified by valid, so they carry no reset.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.misaligned    = misaligned;
    assign bus.busywait      = access_en && ((state_q != S_IDLE) || !hit);
    assign bus.readdata      = (idle_hit && bus.read) ? rd_fmt : '0;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;

`ifdef DCACHE_STATS_EN
    logic        miss_pend_q, miss_pend_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;

    // miss_pend suppresses counting the completing hit of an access that missed.
    always_comb begin
        miss_pend_d  = miss_pend_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (idle_hit) begin
            miss_pend_d = 1'b0;
            if (!miss_pend_q && (hit_count_q != '1)) begin
                hit_count_d = hit_count_q + 32'd1;
            end
        end
        if ((state_q == S_IDLE) && access_en && !hit) begin
            miss_pend_d = 1'b1;
            if (miss_count_q != '1) begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
        if ((state_q == S_WRITEBACK) && !bus.mem_busywait && (wb_count_q != '1)) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss_pend_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            miss_pend_q  <= miss_pend_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: latency-programmable block memory model,
// hand-computed expectations checked with immediate assertions.
module tb_dcache_2way;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   lr = 2;
    int   lw = 1;
    int   rd_cnt = 0;
    int   wr_cnt = 0;

    logic [127:0] mem [0:63];
    logic         mem_loaded = 1'b0;

    int           n_busy, n_rd, n_wr;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;
    logic [31:0]  rdata;
    logic         mis;

    dcache_2way_if #(.WORD_BITS(2)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
    dcache_2way #(.SET_BITS(3), .WORD_BITS(2)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );
`else
    dcache_2way #(.SET_BITS(3), .WORD_BITS(2)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [127:0] pat(input int blk);
        logic [127:0] v;
        for (int w = 0; w < 4; w++) begin
            v[w*32 +: 32] = 32'hB000_0000 | (blk << 8) | w;
        end
        return v;
    endfunction

    // Memory holds busywait for L-1 cycles after a request rises.
    assign bus.mem_busywait = (bus.mem_read && (rd_cnt < lr - 1)) ||
                              (bus.mem_write && (wr_cnt < lw - 1));
    assign bus.mem_readdata = mem[bus.mem_address[5:0]];

    always @(posedge clock) begin
        rd_cnt <= bus.mem_read ? rd_cnt + 1 : 0;
        wr_cnt <= bus.mem_write ? wr_cnt + 1 : 0;
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 4) ? 128'h44444444_33333333_22222222_11111111 : pat(i);
            end
            mem_loaded <= 1'b1;
        end else if (bus.mem_write && !bus.mem_busywait) begin
            mem[bus.mem_address[5:0]] <= bus.mem_writedata;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        bus.read = r; bus.write = w; bus.size = sz; bus.address = a; bus.writedata = wd;
        n_busy = 0; n_rd = 0; n_wr = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        #1;
        while (bus.busywait && (n_busy < 64)) begin
            n_busy++;
            if (bus.mem_read) begin
                n_rd++;
                rd_addr = bus.mem_address;
            end
            if (bus.mem_write) begin
                n_wr++;
                wr_addr = bus.mem_address;
                wr_data = bus.mem_writedata;
            end
            @(posedge clock); #1;
        end
        check("access_done", bus.busywait, 1'b0);
        rdata = bus.readdata;
        mis   = bus.misaligned;
        @(posedge clock); #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.read = 1'b1; bus.write = 1'b0; bus.size = 2'b10;
        bus.address = 32'h40; bus.writedata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busywait", bus.busywait, 1'b0);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_address, 28'h0);
        check("rst_mem_wdata", bus.mem_writedata, 128'h0);
        bus.read = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;

        // Clean miss with Lr=2, then a repeat hit.
        lr = 2; lw = 1;
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        check("t1_busy", n_busy, 4);
        check("t1_rd_cycles", n_rd, 2);
        check("t1_rd_addr", rd_addr, 28'h4);
        check("t1_data", rdata, 32'h11111111);
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        check("t1_hit_busy", n_busy, 0);
        check("t1_hit_data", rdata, 32'h11111111);

        // Byte store into the resident block, then sub-word loads.
        access(1'b0, 1'b1, 2'b00, 32'h41, 32'h000000AB);
        check("t2_wr_busy", n_busy, 0);
        check("t2_wr_traffic", n_rd + n_wr, 0);
        access(1'b1, 1'b0, 2'b01, 32'h40, 32'h0);
        check("t2_half_data", rdata, 32'h0000AB11);
        check("t2_half_busy", n_busy, 0);
        access(1'b1, 1'b0, 2'b00, 32'h41, 32'h0);
        check("t2_byte_data", rdata, 32'h000000AB);

        // Fill both ways of set 4; LRU picks the clean 0xC0 way.
        access(1'b1, 1'b0, 2'b10, 32'hC0, 32'h0);
        check("t3_c0_busy", n_busy, 4);
        check("t3_c0_addr", rd_addr, 28'hC);
        check("t3_c0_data", rdata, 32'hB0000C00);
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        check("t3_touch_busy", n_busy, 0);
        access(1'b1, 1'b0, 2'b10, 32'h140, 32'h0);
        check("t3_140_busy", n_busy, 4);
        check("t3_140_nowb", n_wr, 0);
        check("t3_140_addr", rd_addr, 28'h14);
        check("t3_140_data", rdata, 32'hB0001400);
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        check("t3_40_busy", n_busy, 0);
        check("t3_40_data", rdata, 32'h1111AB11);

        // Dirty eviction with Lw=3, Lr=1.
        lr = 1; lw = 3;
        access(1'b0, 1'b1, 2'b00, 32'h43, 32'h0000005A);
        check("t4_wr_busy", n_busy, 0);
        access(1'b1, 1'b0, 2'b10, 32'hC0, 32'h0);
        check("t4_c0_busy", n_busy, 3);
        check("t4_c0_nowb", n_wr, 0);
        check("t4_c0_data", rdata, 32'hB0000C00);
        access(1'b1, 1'b0, 2'b10, 32'h140, 32'h0);
        check("t4_busy", n_busy, 6);
        check("t4_wb_cycles", n_wr, 3);
        check("t4_wb_addr", wr_addr, 28'h4);
        check("t4_wb_data", wr_data, 128'h44444444_33333333_22222222_5A11AB11);
        check("t4_rd_cycles", n_rd, 1);
        check("t4_rd_addr", rd_addr, 28'h14);
        check("t4_data", rdata, 32'hB0001400);
`ifdef DCACHE_STATS_EN
        check("t4_hit_count", hit_count, 32'd7);
        check("t4_miss_count", miss_count, 32'd5);
        check("t4_wb_count", wb_count, 32'd1);
`endif

        // Reset in the middle of a long refill.
        lr = 5;
        bus.read = 1'b1; bus.write = 1'b0; bus.size = 2'b10; bus.address = 32'h240;
        @(posedge clock); #1;
        check("t5_refill_req", bus.mem_read, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_rst_mem_read", bus.mem_read, 1'b0);
        check("t5_rst_busywait", bus.busywait, 1'b0);
        check("t5_rst_mem_addr", bus.mem_address, 28'h0);
        @(posedge clock); #1;
        bus.read = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        lr = 2;
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        check("t5_remiss_busy", n_busy, 4);
        check("t5_remiss_addr", rd_addr, 28'h4);
        check("t5_remiss_data", rdata, 32'h5A11AB11);

        // Misaligned accesses are ignored by the cache.
        access(1'b1, 1'b0, 2'b01, 32'h41, 32'h0);
        check("t6_mis_flag", mis, 1'b1);
        check("t6_mis_busy", n_busy, 0);
        check("t6_mis_data", rdata, 32'h0);
        access(1'b0, 1'b1, 2'b10, 32'h42, 32'hFFFFFFFF);
        check("t6_miswr_flag", mis, 1'b1);
        access(1'b1, 1'b0, 2'b01, 32'h341, 32'h0);
        check("t6_misrd_busy", n_busy, 0);
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        check("t6_intact_busy", n_busy, 0);
        check("t6_intact_data", rdata, 32'h5A11AB11);

        // Write miss allocates the block, then merges the store.
        lr = 1;
        access(1'b0, 1'b1, 2'b00, 32'h348, 32'h00000077);
        check("t7_wmiss_busy", n_busy, 3);
        check("t7_wmiss_addr", rd_addr, 28'h34);
        access(1'b1, 1'b0, 2'b00, 32'h348, 32'h0);
        check("t7_byte_data", rdata, 32'h00000077);
        access(1'b1, 1'b0, 2'b10, 32'h348, 32'h0);
        check("t7_word_data", rdata, 32'hB0003477);
`ifdef DCACHE_STATS_EN
        check("end_hit_count", hit_count, 32'd3);
        check("end_miss_count", miss_count, 32'd2);
        check("end_wb_count", wb_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
